// File: rtl/button_pkg.sv
// Shared timing constants and per-channel event record for the button debouncer.
package button_pkg;

  localparam int CLK_HZ        = 100_000_000;
  localparam int DEBOUNCE_20MS = CLK_HZ / 50;
  localparam int LONG_500MS    = CLK_HZ / 2;

  typedef struct packed {
    logic press;
    logic rel;
    logic long_p;
    logic long_h;
  } btn_evt_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop sync, debounce counter, press/release pulses and,
// when BUTTON_LONG_PRESS_EN is defined, the long-press hold counter.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS
`ifdef BUTTON_LONG_PRESS_EN
  , parameter int LONG_CYCLES = LONG_500MS
`endif
) (
  input  logic     clk_100M,
  input  logic     rst,
  input  logic     button,
  output logic     level,
  output btn_evt_t evt
);

  localparam int             DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_p, long_h;

  // Any cycle where sync matches the accepted level wipes the count.
  always_comb begin
    sync_d   = {sync_q[0], button};
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == DB_LAST) level_d  = sync_q[1];
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
    press_d = level_d & ~level_q;
    rel_d   = ~level_d & level_q;
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int            HW       = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_p_q, long_p_d;
  logic          long_h_q, long_h_d;

  // Pulse only on the edge into saturation, and never alongside a release.
  always_comb begin
    hold_d = '0;
    if (level_q) hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    long_p_d = level_d && (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
    long_h_d = long_h_q;
    if (rel_d)         long_h_d = 1'b0;
    else if (long_p_d) long_h_d = 1'b1;
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      hold_q   <= '0;
      long_p_q <= 1'b0;
      long_h_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      long_p_q <= long_p_d;
      long_h_q <= long_h_d;
    end
  end

  assign long_p = long_p_q;
  assign long_h = long_h_q;
`else
  assign long_p = 1'b0;
  assign long_h = 1'b0;
`endif

  assign level = level_q;
  assign evt   = '{press: press_q, rel: rel_q, long_p: long_p, long_h: long_h};

endmodule

// File: rtl/button_debounce_array.sv
// N_CH independent debounced buttons with press/release/long-press events.
// Long-press logic is built only when BUTTON_LONG_PRESS_EN is defined.
module button_debounce_array
  import button_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int LONG_CYCLES     = LONG_500MS
) (
  input  logic            clk_100M,
  input  logic            rst,
  input  logic [N_CH-1:0] BUTTON,
  output logic [N_CH-1:0] button_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] long_hold
);

  btn_evt_t [N_CH-1:0] evt;

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || N_CH < 1 || N_CH > 32) begin : g_bad_cfg
    $error("button_debounce_array: illegal parameter combination");
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BUTTON_LONG_PRESS_EN
      , .LONG_CYCLES(LONG_CYCLES)
`endif
    ) u_ch (
      .clk_100M (clk_100M),
      .rst      (rst),
      .button   (BUTTON[gi]),
      .level    (button_level[gi]),
      .evt      (evt[gi])
    );
    assign press_pulse[gi]   = evt[gi].press;
    assign release_pulse[gi] = evt[gi].rel;
    assign long_pulse[gi]    = evt[gi].long_p;
    assign long_hold[gi]     = evt[gi].long_h;
  end

endmodule
